// File: rtl/normalize_round_pack_pkg.sv
// Shared types and helpers for the FP32 adder's normalize/round/pack stage.
// Holds the field widths, the FSM state encoding and the IEEE-754 packing helper.
package normalize_round_pack_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 24;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Build the packed single from sign, biased exponent and fraction field.
    function automatic logic [FP_EXP_W+FP_MANT_W-1:0] pack_fp(
        input logic                  s,
        input logic [FP_EXP_W-1:0]   e,
        input logic [FP_MANT_W-2:0]  f
    );
        return {s, e, f};
    endfunction

endpackage

// File: rtl/normalize_round_pack_rne_rounder.sv
// Round-to-nearest-even increment on a normalised significand.
// A carry out of the top bit re-normalises the significand to 1.000...
module rne_rounder
    import normalize_round_pack_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W
) (
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    output logic [MANT_W-1:0] mant_rnd,
    output logic              mant_ovf
);

    logic              inc;
    logic [MANT_W:0]   sum;

    // Halfway cases (G=1, R=S=0) round up only when the LSB is odd.
    assign inc      = guard & (rnd | sticky | mant[0]);
    assign sum      = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    assign mant_ovf = sum[MANT_W];
    assign mant_rnd = mant_ovf ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];

endmodule

// File: rtl/normalize_round_pack.sv
// FP32 adder back end: iterative one-bit-per-cycle normalisation, RNE rounding
// and IEEE-754 packing, with overflow-to-Inf and flush-to-zero underflow.
module normalize_round_pack
    import normalize_round_pack_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Load,
    input  logic                    S_In,
    input  logic [EXP_W-1:0]        E_In,
    input  logic [MANT_W-1:0]       M_In,
    input  logic                    Carry_In,
    input  logic                    guard_In,
    input  logic                    round_In,
    input  logic                    sticky_In,
    output logic [EXP_W+MANT_W-1:0] Result,
    output logic                    Done,
    output logic                    Busy,
    output logic                    Overflow,
    output logic                    Underflow
);

    // One extra exponent bit so a rounding carry past the max exponent is visible.
    localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    logic [MANT_W-1:0]       mant, mant_nxt, mant_rnd;
    logic                    guard, guard_nxt;
    logic                    rnd, rnd_nxt;
    logic                    sticky, sticky_nxt;
    logic                    carry, carry_nxt;
    logic                    sign, sign_nxt;
    logic [EXP_W:0]          expo, expo_nxt, expo_rnd;
    logic                    mant_ovf;
    logic [EXP_W+MANT_W-1:0] result_nxt;
    logic                    done_nxt, busy_nxt, ovf_nxt, unf_nxt;
    logic                    is_zero;

    rne_rounder #(.MANT_W(MANT_W)) u_rnd (
        .mant     (mant),
        .guard    (guard),
        .rnd      (rnd),
        .sticky   (sticky),
        .mant_rnd (mant_rnd),
        .mant_ovf (mant_ovf)
    );

    assign expo_rnd = expo + {{EXP_W{1'b0}}, mant_ovf};
    assign is_zero  = !carry && (mant == '0) && !guard && !rnd && !sticky;

    always_comb begin
        state_nxt  = state;
        mant_nxt   = mant;
        guard_nxt  = guard;
        rnd_nxt    = rnd;
        sticky_nxt = sticky;
        carry_nxt  = carry;
        sign_nxt   = sign;
        expo_nxt   = expo;
        result_nxt = Result;
        done_nxt   = Done;
        busy_nxt   = Busy;
        ovf_nxt    = Overflow;
        unf_nxt    = Underflow;

        case (state)
            IDLE, DONE: begin
                if (Load) begin
                    state_nxt  = NORM;
                    mant_nxt   = M_In;
                    guard_nxt  = guard_In;
                    rnd_nxt    = round_In;
                    sticky_nxt = sticky_In;
                    carry_nxt  = Carry_In;
                    sign_nxt   = S_In;
                    expo_nxt   = {1'b0, E_In};
                    done_nxt   = 1'b0;
                    busy_nxt   = 1'b1;
                    ovf_nxt    = 1'b0;
                    unf_nxt    = 1'b0;
                end
            end

            NORM: begin
                if (is_zero) begin
                    // Exact cancellation always yields +0.
                    result_nxt = '0;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = DONE;
                end else if (carry) begin
                    mant_nxt   = {1'b1, mant[MANT_W-1:1]};
                    guard_nxt  = mant[0];
                    rnd_nxt    = guard;
                    sticky_nxt = rnd | sticky;
                    carry_nxt  = 1'b0;
                    expo_nxt   = expo + EXP_ONE;
                    state_nxt  = ROUND;
                end else if (!mant[MANT_W-1]) begin
                    if (expo == EXP_ONE) begin
                        result_nxt = {sign, {(EXP_W+MANT_W-1){1'b0}}};
                        unf_nxt    = 1'b1;
                        done_nxt   = 1'b1;
                        busy_nxt   = 1'b0;
                        state_nxt  = DONE;
                    end else begin
                        mant_nxt  = {mant[MANT_W-2:0], guard};
                        guard_nxt = rnd;
                        rnd_nxt   = 1'b0;
                        expo_nxt  = expo - EXP_ONE;
                    end
                end else begin
                    state_nxt = ROUND;
                end
            end

            ROUND: begin
                mant_nxt  = mant_rnd;
                expo_nxt  = expo_rnd;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = DONE;
                if (expo_rnd >= EXP_SAT) begin
                    result_nxt = pack_fp(sign, EXP_MAX, '0);
                    ovf_nxt    = 1'b1;
                end else begin
                    result_nxt = pack_fp(sign, expo_rnd[EXP_W-1:0], mant_rnd[MANT_W-2:0]);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            mant      <= '0;
            guard     <= 1'b0;
            rnd       <= 1'b0;
            sticky    <= 1'b0;
            carry     <= 1'b0;
            sign      <= 1'b0;
            expo      <= '0;
            Result    <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            mant      <= mant_nxt;
            guard     <= guard_nxt;
            rnd       <= rnd_nxt;
            sticky    <= sticky_nxt;
            carry     <= carry_nxt;
            sign      <= sign_nxt;
            expo      <= expo_nxt;
            Result    <= result_nxt;
            Done      <= done_nxt;
            Busy      <= busy_nxt;
            Overflow  <= ovf_nxt;
            Underflow <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_normalize_round_pack.sv
// Scoreboard bench for normalize_round_pack: a driver pushes model predictions,
// a monitor pops and compares on every rising Done.
module tb_normalize_round_pack;

    logic        Clk = 1'b0;
    logic        Reset, Load, S_In, Carry_In, guard_In, round_In, sticky_In;
    logic [7:0]  E_In;
    logic [23:0] M_In;
    logic [31:0] Result;
    logic        Done, Busy, Overflow, Underflow;

    normalize_round_pack dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .S_In      (S_In),
        .E_In      (E_In),
        .M_In      (M_In),
        .Carry_In  (Carry_In),
        .guard_In  (guard_In),
        .round_In  (round_In),
        .sticky_In (sticky_In),
        .Result    (Result),
        .Done      (Done),
        .Busy      (Busy),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        int          load_edge;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    // Reference: value-level normalise / RNE / pack using plain integer arithmetic.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                   input logic c, input logic g, input logic r, input logic st);
        exp_t   x;
        int     k, ee;
        longint ext, mm;
        bit     gg, rr, ss;
        x.ovf = 1'b0;
        x.unf = 1'b0;
        x.load_edge = 0;
        ss = st;
        ee = int'(e);
        if (!c && m == 0 && !g && !r && !st) begin
            x.res = 32'h0;
            x.lat = 1;
            return x;
        end
        if (c) begin
            mm = (longint'(1) << 23) | longint'(m >> 1);
            gg = m[0];
            rr = g;
            ss = r | st;
            ee = ee + 1;
            x.lat = 2;
        end else begin
            k = 0;
            while (k < 24 && m[23-k] == 1'b0) k++;
            if (ee <= k) begin
                x.res = {s, 31'b0};
                x.unf = 1'b1;
                x.lat = ee;
                return x;
            end
            ext = (longint'({m, g, r}) << k) & 64'h3FF_FFFF;
            mm  = ext >> 2;
            gg  = ext[1];
            rr  = ext[0];
            ee  = ee - k;
            x.lat = k + 2;
        end
        if (gg && (rr || ss || mm[0])) mm = mm + 1;
        if (mm == (longint'(1) << 24)) begin
            mm = longint'(1) << 23;
            ee = ee + 1;
        end
        if (ee >= 255) begin
            x.res = {s, 8'hFF, 23'b0};
            x.ovf = 1'b1;
        end else begin
            x.res = {s, ee[7:0], mm[22:0]};
        end
        return x;
    endfunction

    // Called at a negedge; returns at the negedge where Done is observed.
    task automatic issue(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                         input logic g, input logic r, input logic st, input bit track, input bit poke);
        exp_t x;
        int   n;
        x = model(s, e, m, c, g, r, st);
        S_In = s; E_In = e; M_In = m; Carry_In = c;
        guard_In = g; round_In = r; sticky_In = st;
        Load = 1'b1;
        x.load_edge = cyc + 1;
        if (track) sb.push_back(x);
        @(negedge Clk);
        Load = 1'b0;
        if (!track) return;
        n = 0;
        while (!Done && n < 40) begin
            chk("busy_while_running", {31'b0, Busy}, 32'd1);
            // A Load during an operation must not disturb it.
            Load = poke && (n == 3);
            if (Load) begin
                E_In = 8'($urandom); M_In = 24'($urandom); Carry_In = 1'b1; S_In = ~s;
            end
            @(negedge Clk);
            n++;
        end
        Load = 1'b0;
        if (!Done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: actual no Done after %0d cycles, required Done", n);
        end else begin
            chk("busy_at_done", {31'b0, Busy}, 32'd0);
        end
    endtask

    logic prev_done = 1'b0;
    always @(negedge Clk) begin
        exp_t x;
        if (Done && !prev_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: actual result %h, required no Done", Result);
            end else begin
                x = sb.pop_front();
                chk("result", Result, x.res);
                chk("overflow", {31'b0, Overflow}, {31'b0, x.ovf});
                chk("underflow", {31'b0, Underflow}, {31'b0, x.unf});
                chk("latency", cyc - x.load_edge, x.lat);
            end
        end
        prev_done <= Done;
    end

    initial begin
        logic [23:0] mr;
        logic [7:0]  er;
        int          sel;
        Reset = 1'b1; Load = 1'b0; S_In = 1'b0; E_In = '0; M_In = '0;
        Carry_In = 1'b0; guard_In = 1'b0; round_In = 1'b0; sticky_In = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("reset_result", Result, 32'h0);
        chk("reset_done", {31'b0, Done}, 32'd0);
        chk("reset_busy", {31'b0, Busy}, 32'd0);
        chk("reset_flags", {30'b0, Overflow, Underflow}, 32'd0);

        // Directed cases
        issue(1'b0, 8'd130, 24'h802000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(1'b1, 8'd120, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(1'b1, 8'd120, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(1'b0, 8'd130, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        issue(1'b0, 8'd130, 24'h800001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        issue(1'b0, 8'd130, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        issue(1'b0, 8'd130, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0);
        issue(1'b0, 8'd254, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(1'b1, 8'd254, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0);
        issue(1'b0, 8'd1,   24'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
        issue(1'b1, 8'd3,   24'h100000, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0);

        // Abort mid-normalisation; no Done may appear for this operand.
        issue(1'b0, 8'd130, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_result", Result, 32'h0);
        chk("abort_done", {31'b0, Done}, 32'd0);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_flags", {30'b0, Overflow, Underflow}, 32'd0);
        issue(1'b0, 8'd130, 24'h802000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

        // Randomised operands
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 19);
            er  = 8'($urandom_range(1, 254));
            if (sel == 19) er = 8'($urandom_range(1, 24));
            if (sel == 0) begin
                issue(1'($urandom), er, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
            end else begin
                mr = 24'($urandom);
                mr = mr >> $urandom_range(0, 23);
                if (sel >= 5 && mr == 24'h0) mr = 24'h1;
                issue(1'($urandom), er, mr, sel < 5, 1'($urandom), 1'($urandom), 1'($urandom),
                      1, (i % 37) == 0);
            end
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
